apsk_symbol_lut: RTL and testbench
==================================

// Module: apsk_symbol_lut
// PURPOSE
//   Programmable constellation mapper for the APSK modulator datapath.
//   - Maps each input symbol index (AXI-Stream) to a packed {I,Q} sample (AXI-Stream).
//   - The mapping table is written over a separate AXI-Stream load port.
//   - Sits between the bit-slicer (symbol index) and the I/Q pulse-shaping filters.
// PARAMETERS
//   TDATA_WIDTH    32  table entry / output width; entry = {I[TDATA_WIDTH-1:TDATA_WIDTH/2], Q[TDATA_WIDTH/2-1:0]}
//   ADDRESS_WIDTH  8   symbol index width; table depth = 2**ADDRESS_WIDTH
// PORTS
//   aclk              in   1              single clock for all interfaces
//   aresetn           in   1              asynchronous, active-low reset
//   data_in_tready    out  1              symbol index accepted
//   data_in_tdata     in   ADDRESS_WIDTH  symbol index (table address)
//   data_in_tlast     in   1              last symbol of frame
//   data_in_tvalid    in   1              symbol index valid
//   data_out_tready   in   1              downstream ready
//   data_out_tdata    out  TDATA_WIDTH    table entry {I,Q}
//   data_out_tlast    out  1              tlast of the index that produced this entry
//   data_out_tvalid   out  1              output valid
//   data_load_tready  out  1              table load ready
//   data_load_tdata   in   TDATA_WIDTH    table entry to write
//   data_load_tlast   in   1              last entry of table load
//   data_load_tvalid  in   1              table load valid
// BEHAVIOUR
//   Reset (aresetn=0, async): data_out_tvalid=0, data_out_tdata=0, data_out_tlast=0,
//     load pointer=0. Table contents are NOT cleared.
//     data_in_tready=1 and data_load_tready=1 as soon as reset is released.
//   Lookup path: single-stage registered AXI-Stream pipeline.
//   - data_in_tready = !data_out_tvalid | data_out_tready (combinational).
//   - Accept (data_in_tvalid & data_in_tready) at edge N:
//     data_out_tdata<=mem[data_in_tdata], data_out_tlast<=data_in_tlast, data_out_tvalid<=1.
//     Output is visible after edge N (latency 1 clock).
//   - Output consumed with no new accept: data_out_tvalid<=0; tdata/tlast hold their values.
//   - Stall (tvalid=1, tready=0): tdata, tlast and tvalid hold stable; no input is accepted.
//   - Full throughput: one symbol per clock while data_out_tready=1.
//   Load path:
//   - data_load_tready is always 1 out of reset.
//   - Each accepted beat writes mem[ptr]<=data_load_tdata; ptr increments modulo 2**ADDRESS_WIDTH.
//   - A beat with tlast writes, then sets ptr<=0 so the next load restarts at entry 0.
//   - Loading fewer than 2**ADDRESS_WIDTH entries leaves the higher entries unchanged.
//   Simultaneous events:
//   - Load write and lookup read of the same address in the same cycle: the lookup
//     returns the OLD entry (read-before-write). The new entry is seen on later reads.
//   - Load and lookup proceed independently every cycle.
//   Reset mid-operation: any in-flight output is dropped (tvalid=0). ptr returns to 0.
//   Memory: synchronous-write, registered-read RAM, inferable as block/distributed RAM.
// TESTING
//   T1 Load entries 0..3 = 32'h7FFF_0000, 32'h0000_7FFF, 32'h8001_0000, 32'h0000_8001
//      (tlast on 4th); send indices 2,0,3,1 with out_tready=1
//      -> outputs 8001_0000, 7FFF_0000, 0000_8001, 0000_7FFF, each 1 clk after accept.
//   T2 Index stream with data_out_tready=0 for 3 cycles -> one output held stable,
//      data_in_tready=0 during the stall, no loss or duplication after release.
//   T3 Input tlast on the 5th index -> data_out_tlast=1 only on the 5th output.
//   T4 Load 2 entries with tlast, then reload 1 entry 32'h1234_5678
//      -> entry 0 = 1234_5678, entry 1 unchanged.
//   T5 Same-cycle load write and lookup of address 0 -> old value out;
//      next lookup of address 0 -> new value.
//   T6 Assert aresetn=0 while data_out_tvalid=1 -> tvalid/tdata/tlast drop to 0 immediately;
//      the next load after release starts at entry 0.

Source files
------------

// File: rtl/apsk_symbol_lut_if.sv
// Stream bundle for the APSK constellation mapper: symbol-index input,
// {I,Q} sample output and table-load port, all on one clock.
interface apsk_symbol_lut_if #(
    parameter int TDATA_WIDTH   = 32,
    parameter int ADDRESS_WIDTH = 8
);
    // Symbol index stream (from the bit-slicer)
    logic                     data_in_tready;
    logic [ADDRESS_WIDTH-1:0] data_in_tdata;
    logic                     data_in_tlast;
    logic                     data_in_tvalid;

    // {I,Q} sample stream (to the pulse-shaping filters)
    logic                     data_out_tready;
    logic [TDATA_WIDTH-1:0]   data_out_tdata;
    logic                     data_out_tlast;
    logic                     data_out_tvalid;

    // Constellation table load stream
    logic                     data_load_tready;
    logic [TDATA_WIDTH-1:0]   data_load_tdata;
    logic                     data_load_tlast;
    logic                     data_load_tvalid;

    // Side that drives indices, table entries and output back-pressure
    modport master (
        input  data_in_tready,
        output data_in_tdata,
        output data_in_tlast,
        output data_in_tvalid,
        output data_out_tready,
        input  data_out_tdata,
        input  data_out_tlast,
        input  data_out_tvalid,
        input  data_load_tready,
        output data_load_tdata,
        output data_load_tlast,
        output data_load_tvalid
    );

    // Mapper side
    modport slave (
        output data_in_tready,
        input  data_in_tdata,
        input  data_in_tlast,
        input  data_in_tvalid,
        input  data_out_tready,
        output data_out_tdata,
        output data_out_tlast,
        output data_out_tvalid,
        output data_load_tready,
        input  data_load_tdata,
        input  data_load_tlast,
        input  data_load_tvalid
    );
endinterface

// File: rtl/apsk_symbol_lut.sv
// Programmable APSK constellation mapper. Each accepted symbol index reads
// one {I,Q} entry from a table RAM into a single registered output stage.
// The table is filled sequentially over the load stream; a beat with tlast
// rewinds the write pointer so the next load starts again at entry 0.
module apsk_symbol_lut #(
    parameter int TDATA_WIDTH   = 32,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic aclk,
    input  logic aresetn,
    apsk_symbol_lut_if.slave axis
);
    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

    // Table RAM: synchronous write, read captured by the output register
    logic [TDATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic                     out_valid_q, out_valid_d;
    logic [TDATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;

    logic                     in_ready;
    logic                     in_fire;
    logic                     out_fire;
    logic                     load_fire;

    // Handshake qualifiers; the load port never back-pressures
    always_comb begin
        in_ready  = !out_valid_q || axis.data_out_tready;
        in_fire   = axis.data_in_tvalid && in_ready;
        out_fire  = out_valid_q && axis.data_out_tready;
        load_fire = axis.data_load_tvalid;
    end

    // Output stage next state: load on accept, clear valid on drain, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[axis.data_in_tdata];
            out_last_d  = axis.data_in_tlast;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Load pointer next state: wraps naturally, rewinds after a tlast beat
    always_comb begin
        ptr_d = ptr_q;
        if (load_fire) begin
            if (axis.data_load_tlast) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ADDRESS_WIDTH'(1);
            end
        end
    end

    // Control and output registers with asynchronous active-low reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Table write; contents survive reset. A same-cycle lookup of the
    // written address sees the old entry because both update on one edge.
    always_ff @(posedge aclk) begin
        if (load_fire) begin
            mem_q[ptr_q] <= axis.data_load_tdata;
        end
    end

    assign axis.data_in_tready   = in_ready;
    assign axis.data_out_tdata   = out_data_q;
    assign axis.data_out_tlast   = out_last_q;
    assign axis.data_out_tvalid  = out_valid_q;
    assign axis.data_load_tready = 1'b1;

endmodule

// File: tb/tb_apsk_symbol_lut.sv
// Self-checking bench for apsk_symbol_lut: directed scenarios plus a
// randomized run, all compared against a table/queue reference model.
module tb_apsk_symbol_lut;
    localparam int TW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic aclk;
    logic aresetn;

    apsk_symbol_lut_if #(.TDATA_WIDTH(TW), .ADDRESS_WIDTH(AW)) bus ();

    apsk_symbol_lut #(.TDATA_WIDTH(TW), .ADDRESS_WIDTH(AW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axis    (bus.slave)
    );

    // Clock generation
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: table contents, load pointer, in-flight outputs
    typedef struct {
        logic [TW-1:0] data;
        logic          last;
    } ent_t;

    logic [TW-1:0] mem_m [DEPTH];
    int unsigned   ptr_m;
    ent_t          sb [$];
    logic [TW-1:0] hold_data;
    logic          hold_last;

    int checks;
    int errors;

    logic [TW-1:0] tbl [4];

    // Return the model to its post-reset state (table is kept)
    task automatic model_reset();
        sb.delete();
        ptr_m     = 0;
        hold_data = '0;
        hold_last = 1'b0;
    endtask

    // Drive every input to its quiet value
    task automatic idle();
        bus.data_in_tvalid   = 1'b0;
        bus.data_in_tdata    = '0;
        bus.data_in_tlast    = 1'b0;
        bus.data_out_tready  = 1'b1;
        bus.data_load_tvalid = 1'b0;
        bus.data_load_tdata  = '0;
        bus.data_load_tlast  = 1'b0;
    endtask

    // Advance one clock (inputs already applied) and update the model;
    // returns at the following falling edge
    task automatic step();
        bit            in_fire, out_fire, ld_fire;
        logic [AW-1:0] idx;
        logic          ilast, llast;
        logic [TW-1:0] ldata;
        ent_t          e;
        in_fire  = bus.data_in_tvalid && (sb.size() == 0 || bus.data_out_tready);
        out_fire = (sb.size() != 0) && bus.data_out_tready;
        ld_fire  = bus.data_load_tvalid;
        idx      = bus.data_in_tdata;
        ilast    = bus.data_in_tlast;
        ldata    = bus.data_load_tdata;
        llast    = bus.data_load_tlast;
        @(posedge aclk);
        if (out_fire) void'(sb.pop_front());
        if (in_fire) begin
            e.data    = mem_m[idx];
            e.last    = ilast;
            sb.push_back(e);
            hold_data = e.data;
            hold_last = e.last;
        end
        if (ld_fire) begin
            mem_m[ptr_m] = ldata;
            ptr_m = llast ? 0 : (ptr_m + 1) % DEPTH;
        end
        @(negedge aclk);
    endtask

    // Reset values while held in reset and ready flags right after release
    task automatic test_reset();
        idle();
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if (bus.data_out_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid got %b want 0", bus.data_out_tvalid);
        end
        checks++;
        if (bus.data_out_tdata !== '0) begin
            errors++; $display("FAIL reset_tdata got %h want 0", bus.data_out_tdata);
        end
        checks++;
        if (bus.data_out_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_tlast got %b want 0", bus.data_out_tlast);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (bus.data_in_tready !== 1'b1) begin
            errors++; $display("FAIL reset_in_tready got %b want 1", bus.data_in_tready);
        end
        checks++;
        if (bus.data_load_tready !== 1'b1) begin
            errors++; $display("FAIL reset_load_tready got %b want 1", bus.data_load_tready);
        end
        @(negedge aclk);
    endtask

    // Load four entries then look them up out of order, one per clock
    task automatic test_basic_lookup();
        logic [AW-1:0] order [4];
        logic [TW-1:0] want  [4];
        tbl[0] = 32'h7FFF_0000; tbl[1] = 32'h0000_7FFF;
        tbl[2] = 32'h8001_0000; tbl[3] = 32'h0000_8001;
        order[0] = 8'd2; order[1] = 8'd0; order[2] = 8'd3; order[3] = 8'd1;
        want[0] = 32'h8001_0000; want[1] = 32'h7FFF_0000;
        want[2] = 32'h0000_8001; want[3] = 32'h0000_7FFF;
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.data_load_tvalid = 1'b1;
            bus.data_load_tdata  = tbl[i];
            bus.data_load_tlast  = (i == 3);
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.data_in_tvalid = 1'b1;
            bus.data_in_tdata  = order[i];
            #1;
            checks++;
            if (bus.data_in_tready !== 1'b1) begin
                errors++; $display("FAIL lookup_in_tready[%0d] got %b want 1", i, bus.data_in_tready);
            end
            step();
            checks++;
            if (bus.data_out_tvalid !== 1'b1 || bus.data_out_tdata !== want[i]) begin
                errors++;
                $display("FAIL lookup_out[%0d] got v=%b d=%h want v=1 d=%h",
                         i, bus.data_out_tvalid, bus.data_out_tdata, want[i]);
            end
        end
        idle();
        step();
        checks++;
        if (bus.data_out_tvalid !== 1'b0 || bus.data_out_tdata !== 32'h0000_7FFF) begin
            errors++;
            $display("FAIL lookup_drain got v=%b d=%h want v=0 d=00007fff",
                     bus.data_out_tvalid, bus.data_out_tdata);
        end
    endtask

    // Back-pressure for three cycles: output held, input blocked, no loss
    task automatic test_stall();
        idle();
        bus.data_in_tvalid  = 1'b1;
        bus.data_in_tdata   = 8'd0;
        bus.data_out_tready = 1'b0;
        step();
        bus.data_in_tdata = 8'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.data_in_tready !== 1'b0) begin
                errors++; $display("FAIL stall_in_tready[%0d] got %b want 0", i, bus.data_in_tready);
            end
            step();
            checks++;
            if (bus.data_out_tvalid !== 1'b1 || bus.data_out_tdata !== 32'h7FFF_0000) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b d=%h want v=1 d=7fff0000",
                         i, bus.data_out_tvalid, bus.data_out_tdata);
            end
        end
        bus.data_out_tready = 1'b1;
        #1;
        checks++;
        if (bus.data_in_tready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready got %b want 1", bus.data_in_tready);
        end
        step();
        checks++;
        if (bus.data_out_tvalid !== 1'b1 || bus.data_out_tdata !== 32'h0000_7FFF) begin
            errors++;
            $display("FAIL stall_next got v=%b d=%h want v=1 d=00007fff",
                     bus.data_out_tvalid, bus.data_out_tdata);
        end
        idle();
        step();
        checks++;
        if (bus.data_out_tvalid !== 1'b0) begin
            errors++; $display("FAIL stall_no_dup got v=%b want 0", bus.data_out_tvalid);
        end
    endtask

    // tlast on the fifth index appears only on the fifth output
    task automatic test_tlast();
        logic [AW-1:0] idx;
        idle();
        for (int i = 0; i < 5; i++) begin
            idx = AW'($urandom_range(0, 3));
            bus.data_in_tvalid = 1'b1;
            bus.data_in_tdata  = idx;
            bus.data_in_tlast  = (i == 4);
            step();
            checks++;
            if (bus.data_out_tlast !== (i == 4) || bus.data_out_tdata !== tbl[idx]) begin
                errors++;
                $display("FAIL tlast[%0d] got l=%b d=%h want l=%b d=%h",
                         i, bus.data_out_tlast, bus.data_out_tdata, (i == 4), tbl[idx]);
            end
        end
        idle();
        step();
    endtask

    // Two-entry load, then a one-entry reload rewrites only entry 0
    task automatic test_reload();
        logic [TW-1:0] a, b;
        a = $urandom;
        b = $urandom;
        idle();
        bus.data_load_tvalid = 1'b1;
        bus.data_load_tdata  = a;
        step();
        bus.data_load_tdata  = b;
        bus.data_load_tlast  = 1'b1;
        step();
        bus.data_load_tdata  = 32'h1234_5678;
        step();
        idle();
        bus.data_in_tvalid = 1'b1;
        bus.data_in_tdata  = 8'd0;
        step();
        checks++;
        if (bus.data_out_tdata !== 32'h1234_5678) begin
            errors++; $display("FAIL reload_entry0 got %h want 12345678", bus.data_out_tdata);
        end
        bus.data_in_tdata = 8'd1;
        step();
        checks++;
        if (bus.data_out_tdata !== b) begin
            errors++; $display("FAIL reload_entry1 got %h want %h", bus.data_out_tdata, b);
        end
        tbl[1] = b;
        idle();
        step();
    endtask

    // Same-cycle write and read of entry 0 returns the old entry
    task automatic test_collision();
        logic [TW-1:0] nv;
        nv = $urandom | 32'h1;
        idle();
        bus.data_load_tvalid = 1'b1;
        bus.data_load_tdata  = nv;
        bus.data_in_tvalid   = 1'b1;
        bus.data_in_tdata    = 8'd0;
        step();
        checks++;
        if (bus.data_out_tdata !== 32'h1234_5678) begin
            errors++; $display("FAIL collide_old got %h want 12345678", bus.data_out_tdata);
        end
        bus.data_load_tvalid = 1'b0;
        step();
        checks++;
        if (bus.data_out_tdata !== nv) begin
            errors++; $display("FAIL collide_new got %h want %h", bus.data_out_tdata, nv);
        end
        idle();
        step();
    endtask

    // Reset with a held output drops it at once; next load starts at entry 0
    task automatic test_reset_midflight();
        logic [TW-1:0] c;
        c = $urandom;
        idle();
        bus.data_in_tvalid  = 1'b1;
        bus.data_in_tdata   = 8'd0;
        bus.data_in_tlast   = 1'b1;
        bus.data_out_tready = 1'b0;
        step();
        aresetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.data_out_tvalid !== 1'b0 || bus.data_out_tdata !== '0 || bus.data_out_tlast !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop got v=%b d=%h l=%b want 0/0/0",
                     bus.data_out_tvalid, bus.data_out_tdata, bus.data_out_tlast);
        end
        idle();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        bus.data_load_tvalid = 1'b1;
        bus.data_load_tdata  = c;
        step();
        idle();
        bus.data_in_tvalid = 1'b1;
        bus.data_in_tdata  = 8'd0;
        step();
        checks++;
        if (bus.data_out_tdata !== c) begin
            errors++; $display("FAIL midreset_ptr0 got %h want %h", bus.data_out_tdata, c);
        end
        bus.data_in_tdata = 8'd1;
        step();
        checks++;
        if (bus.data_out_tdata !== tbl[1]) begin
            errors++; $display("FAIL midreset_entry1 got %h want %h", bus.data_out_tdata, tbl[1]);
        end
        idle();
        step();
    endtask

    // Full random table, then random traffic on all three streams
    task automatic test_random();
        bit exp_rdy;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            bus.data_load_tvalid = 1'b1;
            bus.data_load_tdata  = $urandom;
            bus.data_load_tlast  = (i == DEPTH - 1);
            step();
        end
        idle();
        for (int n = 0; n < 600; n++) begin
            bus.data_in_tvalid   = ($urandom_range(0, 3) != 0);
            bus.data_in_tdata    = AW'($urandom);
            bus.data_in_tlast    = ($urandom_range(0, 3) == 0);
            bus.data_out_tready  = ($urandom_range(0, 2) != 0);
            bus.data_load_tvalid = ($urandom_range(0, 7) == 0);
            bus.data_load_tdata  = $urandom;
            bus.data_load_tlast  = ($urandom_range(0, 3) == 0);
            #1;
            exp_rdy = (sb.size() == 0) || bus.data_out_tready;
            checks++;
            if (bus.data_in_tready !== exp_rdy) begin
                errors++; $display("FAIL rand_ready[%0d] got %b want %b", n, bus.data_in_tready, exp_rdy);
            end
            step();
            checks++;
            if (bus.data_out_tvalid !== (sb.size() != 0) || bus.data_out_tdata !== hold_data
                || bus.data_out_tlast !== hold_last) begin
                errors++;
                $display("FAIL rand_out[%0d] got v=%b d=%h l=%b want v=%b d=%h l=%b",
                         n, bus.data_out_tvalid, bus.data_out_tdata, bus.data_out_tlast,
                         (sb.size() != 0), hold_data, hold_last);
            end
        end
        idle();
        step();
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Scenario sequence and summary
    initial begin
        checks = 0;
        errors = 0;
        ptr_m  = 0;
        idle();
        test_reset();
        test_basic_lookup();
        test_stall();
        test_tlast();
        test_reload();
        test_collision();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
